match_scoreboard: RTL and testbench
===================================

# match_scoreboard

Downstream stage of the number-guessing game: consumes the 2-bit per-round `Result` code from the game core and keeps a best-of-N match score. It detects each new round outcome, tallies wins per player and rounds played, and declares a match winner. The match ends when a player reaches the target score or the round limit is exhausted. It runs on the same 20 ns system clock as the game core.

## Interface
- `WIN_TARGET`, 3: wins needed to take the match (1..2^CNT_W-1).
- `MAX_ROUNDS`, 9: round limit per match (≥ 2*WIN_TARGET-1, ≤ 2^CNT_W-1).
- `CNT_W`, 4: width of score and round counters.

- `Clock`  in  1  system clock (20 ns).
- `Reset`  in  1  asynchronous, active-low reset.
- `Result`  in  2  round outcome: 00 none, 10 player 1, 01 player 2, 11 tie.
- `Next_match`  in  1  one-cycle pulse; abort or finish the current match and start a new one.
- `Score_1`  out  CNT_W  player 1 wins this match.
- `Score_2`  out  CNT_W  player 2 wins this match.
- `Round_cnt`  out  CNT_W  rounds counted this match.
- `Round_event`  out  1  one-cycle pulse when a round outcome is accepted.
- `Match_over`  out  1  high while in OVER.
- `Match_winner`  out  2  00 undecided, 10 player 1, 01 player 2, 11 drawn match.

## Operation
- Two register stages on `Result`: `res_q`, then `res_qq`. `new_evt` = (`res_q` != 00) && (`res_q` != `res_qq`).
  - A change between two different nonzero codes is a new event.
  - A code held for many cycles counts once.
- FSM states:
  - ARM (reset state): wait until `res_q` == 00, then go to PLAY. Events seen in ARM are ignored, so a stale result is never counted.
  - PLAY: on `new_evt`, update counters and pulse `Round_event`.
    - 10: `Score_1`+1, `Round_cnt`+1.
    - 01: `Score_2`+1, `Round_cnt`+1.
    - 11: `Round_cnt`+1 only (see Configuration).
  - PLAY exits to OVER in the same update when either condition below holds:
    - A score reaches `WIN_TARGET`: `Match_winner` is that player.
    - `Round_cnt` reaches `MAX_ROUNDS`: `Match_winner` is the higher score, or 11 if the scores are equal.
    - If both hold, the `WIN_TARGET` winner takes precedence.
  - OVER: counters and `Match_winner` frozen; further events ignored and `Round_event` stays low.
- `Next_match` in any state:
  - Clears the scores, `Round_cnt` and `Match_winner`; goes to ARM.
  - Takes priority over a `new_evt` in the same cycle; that event is dropped.
- Counters never wrap. The parameter limits guarantee the match terminates before any counter overflows.

## Timing
- Reset values: `Score_1` = `Score_2` = `Round_cnt` = 0, `Round_event` = 0, `Match_over` = 0, `Match_winner` = 00, `res_q` = `res_qq` = 00, state ARM.
- Latency:
  - `Result` changes before edge k.
  - `res_q` updates at edge k.
  - Counters, `Round_event`, `Match_over` and `Match_winner` update at edge k+1.
- `Round_event` is high for exactly the cycle after the counter update edge.
- `Match_over` rises on the same edge as the final score update.
- `Next_match` sampled at edge k: outputs cleared after edge k. The earliest countable event is one whose `res_q` rises at least one edge after ARM has seen `res_q` == 00.
- Asserting `Reset` mid-match clears all state immediately, without waiting for a clock edge.

## Configuration
- `MATCH_TIE_REPLAY_EN`:
  - Defined: a tie (11) does not increment `Round_cnt`. The round is replayed, and `Round_event` still pulses.
  - Undefined: a tie counts toward `MAX_ROUNDS` as described above.

## Test plan
- Reset, then drive `Result` 00→10→00 three times (WIN_TARGET = 3) → `Score_1` = 3, `Round_cnt` = 3, `Match_over` = 1, `Match_winner` = 10; three `Round_event` pulses, each 2 cycles after its `Result` change.
- Hold `Result` = 01 for 20 cycles, then drive 01→10 directly → exactly two events: `Score_2` = 1, `Score_1` = 1.
- MAX_ROUNDS = 5, macro undefined: 10, 01, 11, 11, 11 → OVER after the 5th round, `Match_winner` = 11, scores 1/1. With the macro defined, the same sequence leaves the match in PLAY with `Round_cnt` = 2.
- Pulse `Next_match` in the same cycle as a new event, with `Result` still 10 → all counters 0 and state ARM; the stale 10 is not counted until `Result` returns to 00 and rises again.
- In OVER, apply further 10/01 events → outputs frozen. Drop `Reset` low mid-cycle → all outputs 0 before the next `Clock` edge.

Source files
------------

// File: rtl/match_scoreboard_if.sv
// rtl/match_scoreboard_if.sv - result/control inputs and score outputs of match_scoreboard
`timescale 1ns/1ps

interface match_scoreboard_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       result;
  logic             next_match;
  logic [CNT_W-1:0] score_1;
  logic [CNT_W-1:0] score_2;
  logic [CNT_W-1:0] round_cnt;
  logic             round_event;
  logic             match_over;
  logic [1:0]       match_winner;

  modport master (
    output result, next_match,
    input  score_1, score_2, round_cnt, round_event, match_over, match_winner
  );

  modport slave (
    input  result, next_match,
    output score_1, score_2, round_cnt, round_event, match_over, match_winner
  );
endinterface

// File: rtl/match_scoreboard.sv
// rtl/match_scoreboard.sv - best-of-N match score keeper fed by per-round result codes
// Optional feature macro: MATCH_TIE_REPLAY_EN (ties replayed, not counted as rounds)
`timescale 1ns/1ps

module match_scoreboard #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9,
  parameter int CNT_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  match_scoreboard_if.slave sb_if
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_res_q;
  logic [1:0]       r_res_qq;
  logic [CNT_W-1:0] r_score_1;
  logic [CNT_W-1:0] r_score_2;
  logic [CNT_W-1:0] r_round_cnt;
  logic             r_round_event;
  logic [1:0]       r_winner;

  logic             w_new_evt;
  logic [CNT_W-1:0] w_s1_nxt;
  logic [CNT_W-1:0] w_s2_nxt;
  logic [CNT_W-1:0] w_rc_nxt;
  logic             w_win1;
  logic             w_win2;
  logic             w_rlim;
  logic             w_finish;
  logic [1:0]       w_winner_nxt;
  logic             w_accept;
  logic             w_match_over;

  // Held codes count once; a direct change between two nonzero codes is a new event.
  assign w_new_evt = (r_res_q != 2'b00) && (r_res_q != r_res_qq);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_q  <= 2'b00;
      r_res_qq <= 2'b00;
    end else begin
      r_res_q  <= sb_if.result;
      r_res_qq <= r_res_q;
    end
  end

  always_comb begin
    w_s1_nxt = r_score_1;
    w_s2_nxt = r_score_2;
    w_rc_nxt = r_round_cnt;
    case (r_res_q)
      2'b10: begin
        w_s1_nxt = r_score_1 + CNT_W'(1);
        w_rc_nxt = r_round_cnt + CNT_W'(1);
      end
      2'b01: begin
        w_s2_nxt = r_score_2 + CNT_W'(1);
        w_rc_nxt = r_round_cnt + CNT_W'(1);
      end
      2'b11: begin
`ifdef MATCH_TIE_REPLAY_EN
        w_rc_nxt = r_round_cnt;
`else
        w_rc_nxt = r_round_cnt + CNT_W'(1);
`endif
      end
      default: ;
    endcase
  end

  assign w_win1   = (w_s1_nxt == CNT_W'(WIN_TARGET));
  assign w_win2   = (w_s2_nxt == CNT_W'(WIN_TARGET));
  assign w_rlim   = (w_rc_nxt == CNT_W'(MAX_ROUNDS));
  assign w_finish = w_win1 || w_win2 || w_rlim;

  // Reaching the target beats the round limit when both land on the same round.
  always_comb begin
    w_winner_nxt = 2'b00;
    if (w_win1) begin
      w_winner_nxt = 2'b10;
    end else if (w_win2) begin
      w_winner_nxt = 2'b01;
    end else if (w_rlim) begin
      if (w_s1_nxt > w_s2_nxt) begin
        w_winner_nxt = 2'b10;
      end else if (w_s2_nxt > w_s1_nxt) begin
        w_winner_nxt = 2'b01;
      end else begin
        w_winner_nxt = 2'b11;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (sb_if.next_match) begin
      w_state_nxt = ST_ARM;
    end else begin
      case (r_state)
        ST_ARM:  if (r_res_q == 2'b00) w_state_nxt = ST_PLAY;
        ST_PLAY: if (w_new_evt && w_finish) w_state_nxt = ST_OVER;
        ST_OVER: w_state_nxt = ST_OVER;
        default: w_state_nxt = ST_ARM;
      endcase
    end
  end

  always_comb begin
    w_accept     = 1'b0;
    w_match_over = 1'b0;
    case (r_state)
      ST_PLAY: w_accept     = w_new_evt && !sb_if.next_match;
      ST_OVER: w_match_over = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_score_1     <= '0;
      r_score_2     <= '0;
      r_round_cnt   <= '0;
      r_round_event <= 1'b0;
      r_winner      <= 2'b00;
    end else if (sb_if.next_match) begin
      r_score_1     <= '0;
      r_score_2     <= '0;
      r_round_cnt   <= '0;
      r_round_event <= 1'b0;
      r_winner      <= 2'b00;
    end else if (w_accept) begin
      r_score_1     <= w_s1_nxt;
      r_score_2     <= w_s2_nxt;
      r_round_cnt   <= w_rc_nxt;
      r_round_event <= 1'b1;
      if (w_finish) begin
        r_winner <= w_winner_nxt;
      end
    end else begin
      r_round_event <= 1'b0;
    end
  end

  assign sb_if.score_1      = r_score_1;
  assign sb_if.score_2      = r_score_2;
  assign sb_if.round_cnt    = r_round_cnt;
  assign sb_if.round_event  = r_round_event;
  assign sb_if.match_over   = w_match_over;
  assign sb_if.match_winner = r_winner;

endmodule

// File: tb/tb_match_scoreboard.sv
// tb/tb_match_scoreboard.sv - directed self-checking bench for match_scoreboard
`timescale 1ns/1ps

module tb_match_scoreboard;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   ev_cnt;
  int   ev0;
  int   exp_rc4;
  int   exp_rc5;
  int   exp_over;
  int   exp_win;
  logic [1:0] codes [5];

  match_scoreboard_if #(.CNT_W(4)) sb_if ();

  match_scoreboard #(
    .WIN_TARGET(3),
    .MAX_ROUNDS(5),
    .CNT_W     (4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .sb_if  (sb_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sb_if.round_event) ev_cnt++;
    end
  endtask

  task automatic new_match();
    sb_if.next_match = 1'b1;
    step(1);
    sb_if.next_match = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ev_cnt   = 0;
    rst_n    = 1'b0;
    sb_if.result     = 2'b00;
    sb_if.next_match = 1'b0;
    #35;
    check("rst_score_1", int'(sb_if.score_1), 0);
    check("rst_score_2", int'(sb_if.score_2), 0);
    check("rst_round_cnt", int'(sb_if.round_cnt), 0);
    check("rst_round_event", int'(sb_if.round_event), 0);
    check("rst_match_over", int'(sb_if.match_over), 0);
    check("rst_winner", int'(sb_if.match_winner), 0);
    rst_n = 1'b1;
    step(2);

    // Player 1 wins three straight rounds; event lands two edges after the change.
    for (int i = 1; i <= 3; i++) begin
      sb_if.result = 2'b10;
      step(1);
      check("p1_lat_event_lo", int'(sb_if.round_event), 0);
      check("p1_lat_score", int'(sb_if.score_1), i - 1);
      step(1);
      check("p1_event_hi", int'(sb_if.round_event), 1);
      check("p1_score", int'(sb_if.score_1), i);
      check("p1_over_flag", int'(sb_if.match_over), (i == 3) ? 1 : 0);
      sb_if.result = 2'b00;
      step(1);
      check("p1_event_lo", int'(sb_if.round_event), 0);
    end
    check("p1_round_cnt", int'(sb_if.round_cnt), 3);
    check("p1_winner", int'(sb_if.match_winner), 2);
    check("p1_score_2", int'(sb_if.score_2), 0);

    ev0 = ev_cnt;
    sb_if.result = 2'b01;
    step(2);
    sb_if.result = 2'b10;
    step(2);
    check("over_no_events", ev_cnt - ev0, 0);
    check("over_score_1", int'(sb_if.score_1), 3);
    check("over_score_2", int'(sb_if.score_2), 0);
    check("over_round_cnt", int'(sb_if.round_cnt), 3);
    check("over_winner", int'(sb_if.match_winner), 2);
    check("over_flag", int'(sb_if.match_over), 1);

    // New match while a stale 10 is still on the input.
    new_match();
    check("nm_score_1", int'(sb_if.score_1), 0);
    check("nm_round_cnt", int'(sb_if.round_cnt), 0);
    check("nm_over", int'(sb_if.match_over), 0);
    check("nm_winner", int'(sb_if.match_winner), 0);
    ev0 = ev_cnt;
    step(4);
    check("stale_ignored", int'(sb_if.score_1), 0);
    check("stale_no_event", ev_cnt - ev0, 0);
    sb_if.result = 2'b00;
    step(2);
    sb_if.result = 2'b10;
    step(2);
    check("armed_count", int'(sb_if.score_1), 1);
    check("armed_event", int'(sb_if.round_event), 1);

    // Next_match in the same cycle as a fresh event drops that event.
    sb_if.result = 2'b00;
    step(2);
    sb_if.result = 2'b10;
    step(1);
    sb_if.next_match = 1'b1;
    step(1);
    sb_if.next_match = 1'b0;
    check("nm_evt_score_1", int'(sb_if.score_1), 0);
    check("nm_evt_round_cnt", int'(sb_if.round_cnt), 0);
    check("nm_evt_event", int'(sb_if.round_event), 0);
    ev0 = ev_cnt;
    step(5);
    check("nm_evt_stale", int'(sb_if.score_1), 0);
    check("nm_evt_no_event", ev_cnt - ev0, 0);
    sb_if.result = 2'b00;
    step(3);
    sb_if.result = 2'b10;
    step(2);
    check("nm_evt_recount", int'(sb_if.score_1), 1);

    // Long hold counts once; direct 01->10 is a second event.
    new_match();
    sb_if.result = 2'b00;
    step(3);
    ev0 = ev_cnt;
    sb_if.result = 2'b01;
    step(20);
    sb_if.result = 2'b10;
    step(3);
    check("hold_events", ev_cnt - ev0, 2);
    check("hold_score_1", int'(sb_if.score_1), 1);
    check("hold_score_2", int'(sb_if.score_2), 1);
    check("hold_round_cnt", int'(sb_if.round_cnt), 2);

    // Round limit with ties: 10, 01, 11, 11, 11.
`ifdef MATCH_TIE_REPLAY_EN
    exp_rc4 = 2; exp_rc5 = 2; exp_over = 0; exp_win = 0;
`else
    exp_rc4 = 4; exp_rc5 = 5; exp_over = 1; exp_win = 3;
`endif
    codes[0] = 2'b10; codes[1] = 2'b01; codes[2] = 2'b11; codes[3] = 2'b11; codes[4] = 2'b11;
    new_match();
    sb_if.result = 2'b00;
    step(3);
    ev0 = ev_cnt;
    for (int i = 0; i < 5; i++) begin
      sb_if.result = codes[i];
      step(2);
      sb_if.result = 2'b00;
      step(1);
      if (i == 3) begin
        check("lim_rc4", int'(sb_if.round_cnt), exp_rc4);
        check("lim_over4", int'(sb_if.match_over), 0);
      end
    end
    check("lim_events", ev_cnt - ev0, 5);
    check("lim_round_cnt", int'(sb_if.round_cnt), exp_rc5);
    check("lim_over", int'(sb_if.match_over), exp_over);
    check("lim_winner", int'(sb_if.match_winner), exp_win);
    check("lim_score_1", int'(sb_if.score_1), 1);
    check("lim_score_2", int'(sb_if.score_2), 1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check("arst_score_1", int'(sb_if.score_1), 0);
    check("arst_score_2", int'(sb_if.score_2), 0);
    check("arst_round_cnt", int'(sb_if.round_cnt), 0);
    check("arst_over", int'(sb_if.match_over), 0);
    check("arst_winner", int'(sb_if.match_winner), 0);
    check("arst_event", int'(sb_if.round_event), 0);
    #10;
    rst_n = 1'b1;
    step(2);
    check("post_rst_score_1", int'(sb_if.score_1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
